// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder sequencer.
package rca_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of the nibble index; at least one bit even for tiny configurations.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca4_stage.sv
// Shared 4-bit ripple-carry adder with registered sum and carry-out.
module rca4_stage
  import rca_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] sum_c;
  logic             carry;

  always_comb begin
    sum_c = '0;
    carry = ci;
    for (int i = 0; i < NIB_W; i++) begin
      sum_c[i] = a[i] ^ b[i] ^ carry;
      carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= carry;
    end
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequences a wide add (optionally subtract, RCA_SEQ_SUB_EN) through one shared
// 4-bit registered adder stage, least significant nibble first.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int NIBBLES = 4
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a_in,
  input  logic [NIB_W*NIBBLES-1:0] b_in,
  input  logic                     cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum_out,
  output logic                     cout_out
);

  localparam int W   = NIB_W * NIBBLES;
  localparam int K_W = idx_w(NIBBLES);
  localparam logic [K_W-1:0] K_LAST = K_W'(NIBBLES - 1);

  state_t           state;
  logic [K_W-1:0]   k;
  logic [W-1:0]     a_lat;
  logic [W-1:0]     b_lat;
  logic             cin_lat;
  logic [NIB_W-1:0] st_a;
  logic [NIB_W-1:0] st_b;
  logic             st_ci;
  logic [NIB_W-1:0] st_sum;
  logic             st_co;
`ifdef RCA_SEQ_SUB_EN
  logic             sub_lat;
`endif

  // Nibble k of each operand; the carry chain restarts from the latched carry at k=0.
  always_comb begin
    st_a  = a_lat[NIB_W*k +: NIB_W];
    st_b  = b_lat[NIB_W*k +: NIB_W];
    st_ci = (k == '0) ? cin_lat : st_co;
`ifdef RCA_SEQ_SUB_EN
    if (sub_lat) begin
      st_b = ~st_b;
      if (k == '0) st_ci = 1'b1;
    end
`endif
  end

  rca4_stage u_stage (
    .clk  (clk),
    .rst  (rst),
    .a    (st_a),
    .b    (st_b),
    .ci   (st_ci),
    .sum  (st_sum),
    .cout (st_co)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      cin_lat  <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
      sub_lat  <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat   <= a_in;
            b_lat   <= b_in;
            cin_lat <= cin;
`ifdef RCA_SEQ_SUB_EN
            sub_lat <= sub;
`endif
            k       <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // The stage output lags the presented nibble by one cycle.
          if (k != '0) sum_out[NIB_W*(k - K_W'(1)) +: NIB_W] <= st_sum;
          if (k == K_LAST) state <= DRAIN;
          else             k     <= k + K_W'(1);
        end
        DRAIN: begin
          sum_out[W-1 -: NIB_W] <= st_sum;
          cout_out <= st_co;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed table, hand sequences and random ops.
`timescale 1ns/1ps
module tb_rca_seq_ctrl;
  import rca_seq_pkg::*;

  localparam int N = 4;
  localparam int W = NIB_W * N;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         s;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         sub_s = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub      (sub_s),
`endif
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  // Reference: the whole operation as one wide addition, carry = bit W.
  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic ci, s);
    logic [W:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, b, input logic c, s);
    a_in  = a;
    b_in  = b;
    cin   = c;
    sub_s = s;
    start = 1'b1;
  endtask

  task automatic watch(input int cycles, output int busy_cnt, output int done_cnt,
                       output int first_done, output logic [W-1:0] s_cap, output logic c_cap);
    busy_cnt = 0; done_cnt = 0; first_done = -1; s_cap = '0; c_cap = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = c;
          s_cap = sum_out;
          c_cap = cout_out;
        end
      end
      step();
    end
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, b, input logic c, s,
                       input logic [W-1:0] exp_sum, input logic exp_co);
    int bc, dc, fd;
    logic [W-1:0] sc;
    logic cc;
    applyStimulus(a, b, c, s);
    step();
    start = 1'b0;
    watch(N + 4, bc, dc, fd, sc, cc);
    checkOutput({name, " busy cycles"}, 64'(bc), 64'(N + 1));
    checkOutput({name, " done cycle"}, 64'(fd), 64'(N + 2));
    checkOutput({name, " done count"}, 64'(dc), 64'd1);
    checkOutput({name, " sum"}, 64'(sc), 64'(exp_sum));
    checkOutput({name, " cout"}, 64'(cc), 64'(exp_co));
    checkOutput({name, " sum held"}, 64'(sum_out), 64'(exp_sum));
  endtask

  initial begin
    vec_t vecs[$];
    int bc, dc, fd;
    logic [W-1:0] sc;
    logic cc;
    int first_busy;
    int dones[$];

    vecs.push_back('{a: 16'h1234, b: 16'h4321, ci: 1'b0, s: 1'b0, sum: 16'h5555, co: 1'b0});
    vecs.push_back('{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, s: 1'b0, sum: 16'h0000, co: 1'b1});
    vecs.push_back('{a: 16'hABCD, b: 16'h0000, ci: 1'b1, s: 1'b0, sum: 16'hABCE, co: 1'b0});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, ci: 1'b1, s: 1'b0, sum: 16'hFFFF, co: 1'b1});
    vecs.push_back('{a: 16'h8000, b: 16'h8000, ci: 1'b0, s: 1'b0, sum: 16'h0000, co: 1'b1});
    vecs.push_back('{a: 16'h0F0F, b: 16'h0101, ci: 1'b0, s: 1'b0, sum: 16'h1010, co: 1'b0});
`ifdef RCA_SEQ_SUB_EN
    vecs.push_back('{a: 16'h0005, b: 16'h0007, ci: 1'b0, s: 1'b1, sum: 16'hFFFE, co: 1'b0});
    vecs.push_back('{a: 16'h0009, b: 16'h0003, ci: 1'b0, s: 1'b1, sum: 16'h0006, co: 1'b1});
    vecs.push_back('{a: 16'h0009, b: 16'h0003, ci: 1'b1, s: 1'b1, sum: 16'h0006, co: 1'b1});
`endif

    // Reset state
    step();
    step();
    rst = 1'b1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset sum", 64'(sum_out), 64'd0);
    checkOutput("reset cout", 64'(cout_out), 64'd0);
    step();

    // Directed table
    for (int i = 0; i < vecs.size(); i++)
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s,
            vecs[i].sum, vecs[i].co);

    // Start re-asserted with new operands while busy and during DONE: ignored
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    start = 1'b0;
    bc = 0; dc = 0; sc = '0;
    for (int c = 1; c <= N + 6; c++) begin
      if (c == 2) applyStimulus(16'h1111, 16'h1111, 1'b1, 1'b0);
      if (c == N + 3) start = 1'b0;
      if (busy) bc++;
      if (done) begin dc++; sc = sum_out; end
      step();
    end
    checkOutput("busy-start busy cycles", 64'(bc), 64'(N + 1));
    checkOutput("busy-start done count", 64'(dc), 64'd1);
    checkOutput("busy-start sum", 64'(sc), 64'h5555);

    // Start held continuously: re-accepted on the first IDLE cycle after done
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    step();
    first_busy = -1;
    dones.delete();
    for (int c = 1; c <= 2 * N + 7; c++) begin
      if (c == N + 4) start = 1'b0;
      if (busy && first_busy < 0 && c > N + 2) first_busy = c;
      if (done) dones.push_back(c);
      step();
    end
    checkOutput("held-start done count", 64'(dones.size()), 64'd2);
    checkOutput("held-start rebusy cycle", 64'(first_busy), 64'(N + 4));
    if (dones.size() == 2)
      checkOutput("held-start second done", 64'(dones[1]), 64'(2 * N + 5));
    else
      checkOutput("held-start second done", 64'(-1), 64'(2 * N + 5));
    checkOutput("held-start sum", 64'(sum_out), 64'h1010);

    // Reset mid-RUN at k=2 abandons the operation
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset sum", 64'(sum_out), 64'd0);
    checkOutput("midreset cout", 64'(cout_out), 64'd0);
    watch(N + 4, bc, dc, fd, sc, cc);
    checkOutput("midreset no done", 64'(dc), 64'd0);
    checkOutput("midreset no busy", 64'(bc), 64'd0);
    runOp("post-reset", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0);

    // Reset wins over start on the same edge
    applyStimulus(16'h2222, 16'h3333, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    start = 1'b0;
    checkOutput("reset-vs-start busy", 64'(busy), 64'd0);
    watch(N + 4, bc, dc, fd, sc, cc);
    checkOutput("reset-vs-start no done", 64'(dc), 64'd0);

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      logic [W:0] r;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'b0;
`ifdef RCA_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      r = model(ra, rb, rc, rs);
      runOp($sformatf("rand%0d", i), ra, rb, rc, rs, r[W-1:0], r[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Sequencer that computes wide additions on a single shared 4-bit registered ripple-carry adder stage. It accepts N-nibble operands with a start/busy/done handshake and feeds one nibble per cycle, least significant first, chaining each nibble's registered carry-out into the next nibble's carry-in. It collects the sum nibbles into a result register. It sits between a requesting master and the nibble adder datapath, and owns the adder's sequencing.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal 2..8
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising clk
- start  in  1  request; sampled only in IDLE
- a_in  in  W  operand A; sampled on the accepting edge only
- b_in  in  W  operand B; sampled on the accepting edge only
- cin  in  1  carry-in for nibble 0; sampled on the accepting edge only
- sub  in  1  present only when RCA_SEQ_SUB_EN is defined; sampled on the accepting edge only
- busy  out  1  high from the cycle after acceptance through the cycle before done
- done  out  1  single-cycle completion pulse
- sum_out  out  W  result; held stable from done until the next acceptance
- cout_out  out  1  carry out of the top nibble; held with sum_out

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches a_in, b_in and cin, clears the nibble index k, and moves to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Presents nibble k of A and B to the adder stage.
  - Carry-in is the latched cin for k=0, otherwise the stage's registered cout.
  - From the second RUN cycle on, the stage's registered sum (nibble k-1) is written into sum_out bits [4(k-1)+3:4(k-1)].
  - k increments each cycle; after k=NIBBLES-1 the state moves to DRAIN.
- DRAIN:
  - Writes the last nibble into sum_out.
  - Copies the stage cout into cout_out.
  - Moves to DONE.
- DONE: done=1 for one cycle, then unconditionally back to IDLE. start is ignored in DONE.
- start while busy (RUN/DRAIN/DONE) is ignored, not queued.
- Arithmetic is modulo 2^W. cout_out=1 iff A+B+cin ≥ 2^W.
- sum_out and cout_out are overwritten nibble-by-nibble during an operation; they are valid only from the done cycle onward.

## Timing
- Acceptance edge = edge E0.
- busy=1 for the cycles after E0 through E0+NIBBLES+1.
- done=1 in the cycle after edge E0+NIBBLES+1.
- Latency start→done is NIBBLES+2 cycles (6 for the default).
- Back-to-back: the earliest next acceptance is the first IDLE cycle after done, so throughput is one operation per NIBBLES+3 cycles.
- Reset (rst=0 at an edge, any state including mid-RUN):
  - Returns to IDLE.
  - Clears busy, done, sum_out, cout_out, k, the operand latches, and the adder stage registers.
  - Any in-flight operation is abandoned with no done pulse.
- Reset has priority over start on the same edge.

## Configuration
- RCA_SEQ_SUB_EN defined:
  - Adds the sub port.
  - With sub=1: B nibbles are inverted before the adder, carry-in for nibble 0 is forced to 1, and cin is ignored, so the result is A−B mod 2^W.
  - cout_out=1 means no borrow (A ≥ B).
  - With sub=0: behaviour is identical to the add-only build.
- RCA_SEQ_SUB_EN undefined: no sub port, no inversion logic, add only.

## Structure
- Package rca_seq_pkg holds:
  - The state enum (IDLE, RUN, DRAIN, DONE).
  - Constant NIB_W=4.
  - The index width function or localparam for k (clog2 of NIBBLES).
- Sub-module rca4_stage:
  - 4-bit ripple-carry adder (a, b, ci) with sum and cout registered on clk.
  - Same synchronous active-low rst.
  - One instance only; this is the shared resource.
- Top level holds the FSM, the operand latches, nibble muxing, and the result assembly register.

## Test plan
- Basic add: NIBBLES=4, a_in=0x1234, b_in=0x4321, cin=0, one start pulse → sum_out=0x5555, cout_out=0, done exactly 6 cycles after the accepting edge, busy high 5 cycles.
- Full carry ripple: a_in=0xFFFF, b_in=0x0001, cin=0 → sum_out=0x0000, cout_out=1. Also a_in=0xABCD, b_in=0x0000, cin=1 → 0xABCE, cout 0.
- Start while busy: a second start with new operands held high during RUN → ignored, first result unchanged, exactly one done pulse. Start held continuously → the next acceptance happens the first IDLE cycle after done.
- Reset mid-operation: rst=0 for one edge during RUN k=2 → next cycle busy=0, done=0, sum_out=0, cout_out=0, no done pulse. A subsequent 0x0F0F+0x0101 completes correctly with 0x1010.
- Subtraction (RCA_SEQ_SUB_EN): a_in=0x0005, b_in=0x0007, sub=1 → sum_out=0xFFFE, cout_out=0. a_in=0x0009, b_in=0x0003, sub=1 → 0x0006, cout_out=1.
